// File: rtl/sat_accum.sv
// sat_accum: two-stage pipelined saturating accumulator.
//   Stage 1 clips each valid input sample into the output range.
//   Stage 2 adds the clipped sample to a running total that saturates
//   instead of wrapping, and reports per-sample clip flags.
//   A sticky counter records how many samples hit either rail.
// Ports:
//   clk      rising-edge system clock
//   rst_n    asynchronous active-low reset (all registers to 0)
//   clr      synchronous clear of pipeline, accumulator, flags, counter
//   in_vld   in_data valid this cycle
//   in_data  input sample (IN_W bits, signed or unsigned per SIGNED)
//   out_vld  one-cycle pulse: acc/sat_hi/sat_lo updated for one sample
//   acc      saturated running total (OUT_W bits)
//   sat_hi   reported sample clipped at the top rail (stage 1 or 2)
//   sat_lo   reported sample clipped at the bottom rail (stage 1 or 2)
//   sat_cnt  saturating count of clipped samples
module sat_accum #(
  parameter int IN_W   = 16,
  parameter int OUT_W  = 10,
  parameter int SIGNED = 1,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_vld,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_vld,
  output logic [OUT_W-1:0] acc,
  output logic             sat_hi,
  output logic             sat_lo,
  output logic [CNT_W-1:0] sat_cnt
);

  localparam logic [OUT_W-1:0] MAX_V = (SIGNED != 0) ? {1'b0, {(OUT_W-1){1'b1}}}
                                                     : {OUT_W{1'b1}};
  localparam logic [OUT_W-1:0] MIN_V = (SIGNED != 0) ? {1'b1, {(OUT_W-1){1'b0}}}
                                                     : {OUT_W{1'b0}};

  // Stage 1 registers
  logic             s1_vld_r;
  logic [OUT_W-1:0] s1_data_r;
  logic             s1_hi_r;
  logic             s1_lo_r;

  // Stage 2 / output registers
  logic             out_vld_r;
  logic [OUT_W-1:0] acc_r;
  logic             sat_hi_r;
  logic             sat_lo_r;
  logic [CNT_W-1:0] sat_cnt_r;

  // Combinational intermediates
  logic [IN_W-OUT_W:0] top_s_s;   // bits that must all match the sign when in range
  logic [IN_W-OUT_W:0] top_u_s;   // bits that must all be zero when in range
  logic [OUT_W-1:0]    clip_data_s;
  logic                clip_hi_s;
  logic                clip_lo_s;
  logic [OUT_W:0]      acc_ext_s;
  logic [OUT_W:0]      smp_ext_s;
  logic [OUT_W:0]      sum_s;
  logic                ovf_hi_s;
  logic                ovf_lo_s;
  logic [OUT_W-1:0]    sum_sat_s;
  logic                any_sat_s;

  assign top_s_s = in_data[IN_W-1:OUT_W-1];

  // For unsigned samples only bits above OUT_W matter; a leading zero keeps
  // the vector the same width as the signed test even when IN_W == OUT_W.
  if (IN_W > OUT_W) begin : g_top_wide
    assign top_u_s = {1'b0, in_data[IN_W-1:OUT_W]};
  end else begin : g_top_eq
    assign top_u_s = 1'b0;
  end

  // Stage 1 input clamp into [MIN_V, MAX_V]
  always_comb begin
    clip_data_s = in_data[OUT_W-1:0];
    clip_hi_s   = 1'b0;
    clip_lo_s   = 1'b0;
    if (SIGNED != 0) begin
      if ((&top_s_s) || !(|top_s_s)) begin
        clip_data_s = in_data[OUT_W-1:0];
      end else if (in_data[IN_W-1]) begin
        clip_data_s = MIN_V;
        clip_lo_s   = 1'b1;
      end else begin
        clip_data_s = MAX_V;
        clip_hi_s   = 1'b1;
      end
    end else begin
      if (|top_u_s) begin
        clip_data_s = MAX_V;
        clip_hi_s   = 1'b1;
      end else begin
        clip_data_s = in_data[OUT_W-1:0];
      end
    end
  end

  // Stage 2 one-bit-wider sum and overflow detection
  always_comb begin
    acc_ext_s = {1'b0, acc_r};
    smp_ext_s = {1'b0, s1_data_r};
    ovf_hi_s  = 1'b0;
    ovf_lo_s  = 1'b0;
    if (SIGNED != 0) begin
      acc_ext_s = {acc_r[OUT_W-1], acc_r};
      smp_ext_s = {s1_data_r[OUT_W-1], s1_data_r};
    end else begin
      acc_ext_s = {1'b0, acc_r};
      smp_ext_s = {1'b0, s1_data_r};
    end
    sum_s = acc_ext_s + smp_ext_s;
    // Signed: the two top bits disagree on overflow; 01 = above MAX, 10 = below MIN.
    // Unsigned: a carry out means above MAX; the sum can never go below 0.
    if (SIGNED != 0) begin
      ovf_hi_s = (sum_s[OUT_W:OUT_W-1] == 2'b01);
      ovf_lo_s = (sum_s[OUT_W:OUT_W-1] == 2'b10);
    end else begin
      ovf_hi_s = sum_s[OUT_W];
      ovf_lo_s = 1'b0;
    end
    if (ovf_hi_s) begin
      sum_sat_s = MAX_V;
    end else if (ovf_lo_s) begin
      sum_sat_s = MIN_V;
    end else begin
      sum_sat_s = sum_s[OUT_W-1:0];
    end
    any_sat_s = s1_hi_r | s1_lo_r | ovf_hi_s | ovf_lo_s;
  end

  // Stage 1 register: clipped sample, clip flags and valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_r  <= 1'b0;
      s1_data_r <= {OUT_W{1'b0}};
      s1_hi_r   <= 1'b0;
      s1_lo_r   <= 1'b0;
    end else if (clr) begin
      s1_vld_r  <= 1'b0;
      s1_data_r <= {OUT_W{1'b0}};
      s1_hi_r   <= 1'b0;
      s1_lo_r   <= 1'b0;
    end else begin
      s1_vld_r  <= in_vld;
      s1_data_r <= clip_data_s;
      s1_hi_r   <= clip_hi_s & in_vld;
      s1_lo_r   <= clip_lo_s & in_vld;
    end
  end

  // Stage 2 register: accumulator, output valid and per-sample flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_r <= 1'b0;
      acc_r     <= {OUT_W{1'b0}};
      sat_hi_r  <= 1'b0;
      sat_lo_r  <= 1'b0;
    end else if (clr) begin
      out_vld_r <= 1'b0;
      acc_r     <= {OUT_W{1'b0}};
      sat_hi_r  <= 1'b0;
      sat_lo_r  <= 1'b0;
    end else if (s1_vld_r) begin
      out_vld_r <= 1'b1;
      acc_r     <= sum_sat_s;
      sat_hi_r  <= s1_hi_r | ovf_hi_s;
      sat_lo_r  <= s1_lo_r | ovf_lo_s;
    end else begin
      out_vld_r <= 1'b0;
      acc_r     <= acc_r;
      sat_hi_r  <= 1'b0;
      sat_lo_r  <= 1'b0;
    end
  end

  // Saturation event counter; updates on the same edge as the flags it counts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      sat_cnt_r <= {CNT_W{1'b0}};
    end else if (s1_vld_r && any_sat_s && !(&sat_cnt_r)) begin
      sat_cnt_r <= sat_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      sat_cnt_r <= sat_cnt_r;
    end
  end

  assign out_vld = out_vld_r;
  assign acc     = acc_r;
  assign sat_hi  = sat_hi_r;
  assign sat_lo  = sat_lo_r;
  assign sat_cnt = sat_cnt_r;

endmodule

// File: tb/tb_sat_accum.sv
// Directed testbench for sat_accum: a signed default instance and an
// unsigned instance (OUT_W=10, CNT_W=2) share the same input stimulus.
module tb_sat_accum;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        in_vld;
  logic [15:0] in_data;

  logic        out_vld_s, sat_hi_s, sat_lo_s;
  logic [9:0]  acc_s;
  logic [7:0]  sat_cnt_s;
  logic        out_vld_u, sat_hi_u, sat_lo_u;
  logic [9:0]  acc_u;
  logic [1:0]  sat_cnt_u;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic        v;
    logic        c;
    logic [15:0] d;
    logic [20:0] e;
  } step_t;

  sat_accum #(.IN_W(16), .OUT_W(10), .SIGNED(1), .CNT_W(8)) dut_s (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_vld(in_vld), .in_data(in_data),
    .out_vld(out_vld_s), .acc(acc_s), .sat_hi(sat_hi_s), .sat_lo(sat_lo_s),
    .sat_cnt(sat_cnt_s)
  );

  sat_accum #(.IN_W(16), .OUT_W(10), .SIGNED(0), .CNT_W(2)) dut_u (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_vld(in_vld), .in_data(in_data),
    .out_vld(out_vld_u), .acc(acc_u), .sat_hi(sat_hi_u), .sat_lo(sat_lo_u),
    .sat_cnt(sat_cnt_u)
  );

  always #5 clk = ~clk;

  wire [20:0] obs_s = {out_vld_s, acc_s, sat_hi_s, sat_lo_s, sat_cnt_s};
  wire [20:0] obs_u = {6'd0, out_vld_u, acc_u, sat_hi_u, sat_lo_u, sat_cnt_u};

  // Expected tuple for the signed instance
  function automatic logic [20:0] es(input logic v, input int a, input logic h,
                                     input logic l, input int c);
    logic [31:0] av, cv;
    av = a; cv = c;
    return {v, av[9:0], h, l, cv[7:0]};
  endfunction

  // Expected tuple for the unsigned instance
  function automatic logic [20:0] eu(input logic v, input int a, input logic h,
                                     input logic l, input int c);
    logic [31:0] av, cv;
    av = a; cv = c;
    return {6'd0, v, av[9:0], h, l, cv[1:0]};
  endfunction

  function automatic step_t mk(input logic v, input logic c, input logic [15:0] d,
                               input logic [20:0] e);
    step_t s;
    s.v = v; s.c = c; s.d = d; s.e = e;
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    clr = 1'b1; in_vld = 1'b0; in_data = 16'h0000;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    step_t st[6];
    tick(); tick();
    n_vec++;
    if (obs_s !== 21'd0 || obs_u !== 21'd0) begin
      n_err++;
      $display("FAIL reset_initial: got %h/%h expected 0", obs_s, obs_u);
    end
    rst_n = 1'b1;
    in_vld = 1'b1; in_data = 16'h0003; tick();
    in_data = 16'h0004; tick();
    n_vec++;
    if (obs_s !== es(1'b1, 3, 1'b0, 1'b0, 0)) begin
      n_err++;
      $display("FAIL reset_prestream: got %h expected %h", obs_s, es(1'b1, 3, 1'b0, 1'b0, 0));
    end
    in_data = 16'h0005; tick();
    // Assert reset away from any clock edge, with a sample in flight
    #3 rst_n = 1'b0;
    #1;
    n_vec++;
    if (obs_s !== 21'd0 || obs_u !== 21'd0) begin
      n_err++;
      $display("FAIL reset_async: got %h/%h expected 0", obs_s, obs_u);
    end
    for (int i = 0; i < 4; i++) begin
      in_vld = ~in_vld; in_data = 16'h0100; tick();
      n_vec++;
      if (obs_s !== 21'd0 || obs_u !== 21'd0) begin
        n_err++;
        $display("FAIL reset_hold step %0d: got %h/%h expected 0", i, obs_s, obs_u);
      end
    end
    in_vld = 1'b0;
    rst_n = 1'b1;
    // First sample after release: out_vld two edges later
    st[0] = mk(1'b1, 1'b0, 16'h0009, es(1'b0, 0, 1'b0, 1'b0, 0));
    st[1] = mk(1'b0, 1'b0, 16'h0000, es(1'b1, 9, 1'b0, 1'b0, 0));
    st[2] = mk(1'b0, 1'b0, 16'h0000, es(1'b0, 9, 1'b0, 1'b0, 0));
    st[3] = mk(1'b0, 1'b0, 16'h0000, es(1'b0, 9, 1'b0, 1'b0, 0));
    st[4] = mk(1'b1, 1'b0, 16'h0001, es(1'b0, 9, 1'b0, 1'b0, 0));
    st[5] = mk(1'b0, 1'b0, 16'h0000, es(1'b1, 10, 1'b0, 1'b0, 0));
    for (int i = 0; i < 6; i++) begin
      in_vld = st[i].v; clr = st[i].c; in_data = st[i].d;
      tick();
      n_vec++;
      if (obs_s !== st[i].e) begin
        n_err++;
        $display("FAIL reset_release step %0d: got %h expected %h", i, obs_s, st[i].e);
      end
    end
  endtask

  task automatic test_signed_top();
    step_t st[5];
    do_clr();
    st[0] = mk(1'b1, 1'b0, 16'h01FE, es(1'b0, 0, 1'b0, 1'b0, 0));
    st[1] = mk(1'b1, 1'b0, 16'h0001, es(1'b1, 510, 1'b0, 1'b0, 0));
    st[2] = mk(1'b1, 1'b0, 16'h0001, es(1'b1, 511, 1'b0, 1'b0, 0));
    st[3] = mk(1'b0, 1'b0, 16'h0000, es(1'b1, 511, 1'b1, 1'b0, 1));
    st[4] = mk(1'b0, 1'b0, 16'h0000, es(1'b0, 511, 1'b0, 1'b0, 1));
    for (int i = 0; i < 5; i++) begin
      in_vld = st[i].v; clr = st[i].c; in_data = st[i].d;
      tick();
      n_vec++;
      if (obs_s !== st[i].e) begin
        n_err++;
        $display("FAIL signed_top step %0d: got %h expected %h", i, obs_s, st[i].e);
      end
    end
  endtask

  task automatic test_input_clip();
    step_t st[4];
    do_clr();
    st[0] = mk(1'b1, 1'b0, 16'h0200, es(1'b0, 0, 1'b0, 1'b0, 0));
    st[1] = mk(1'b1, 1'b0, 16'hFC00, es(1'b1, 511, 1'b1, 1'b0, 1));
    st[2] = mk(1'b0, 1'b0, 16'h0000, es(1'b1, 10'h3FF, 1'b0, 1'b1, 2));
    st[3] = mk(1'b0, 1'b0, 16'h0000, es(1'b0, 10'h3FF, 1'b0, 1'b0, 2));
    for (int i = 0; i < 4; i++) begin
      in_vld = st[i].v; clr = st[i].c; in_data = st[i].d;
      tick();
      n_vec++;
      if (obs_s !== st[i].e) begin
        n_err++;
        $display("FAIL input_clip step %0d: got %h expected %h", i, obs_s, st[i].e);
      end
    end
  endtask

  task automatic test_signed_bottom();
    step_t st[5];
    do_clr();
    st[0] = mk(1'b1, 1'b0, 16'hFE00, es(1'b0, 0, 1'b0, 1'b0, 0));
    st[1] = mk(1'b1, 1'b0, 16'hFF00, es(1'b1, 10'h200, 1'b0, 1'b0, 0));
    st[2] = mk(1'b1, 1'b0, 16'h00FF, es(1'b1, 10'h200, 1'b0, 1'b1, 1));
    st[3] = mk(1'b0, 1'b0, 16'h0000, es(1'b1, 10'h2FF, 1'b0, 1'b0, 1));
    st[4] = mk(1'b0, 1'b0, 16'h0000, es(1'b0, 10'h2FF, 1'b0, 1'b0, 1));
    for (int i = 0; i < 5; i++) begin
      in_vld = st[i].v; clr = st[i].c; in_data = st[i].d;
      tick();
      n_vec++;
      if (obs_s !== st[i].e) begin
        n_err++;
        $display("FAIL signed_bottom step %0d: got %h expected %h", i, obs_s, st[i].e);
      end
    end
  endtask

  task automatic test_clr_collision();
    step_t st[4];
    // Starts from acc=0x2FF, sat_cnt=1 left by the bottom-edge test
    st[0] = mk(1'b1, 1'b0, 16'h0005, es(1'b0, 10'h2FF, 1'b0, 1'b0, 1));
    st[1] = mk(1'b1, 1'b1, 16'h0007, es(1'b0, 0, 1'b0, 1'b0, 0));
    st[2] = mk(1'b0, 1'b0, 16'h0000, es(1'b0, 0, 1'b0, 1'b0, 0));
    st[3] = mk(1'b0, 1'b0, 16'h0000, es(1'b0, 0, 1'b0, 1'b0, 0));
    for (int i = 0; i < 4; i++) begin
      in_vld = st[i].v; clr = st[i].c; in_data = st[i].d;
      tick();
      n_vec++;
      if (obs_s !== st[i].e) begin
        n_err++;
        $display("FAIL clr_collision step %0d: got %h expected %h", i, obs_s, st[i].e);
      end
    end
  endtask

  task automatic test_back_to_back();
    step_t st[5];
    do_clr();
    st[0] = mk(1'b1, 1'b0, 16'h0001, es(1'b0, 0, 1'b0, 1'b0, 0));
    st[1] = mk(1'b1, 1'b0, 16'h0002, es(1'b1, 1, 1'b0, 1'b0, 0));
    st[2] = mk(1'b1, 1'b0, 16'hFFFD, es(1'b1, 3, 1'b0, 1'b0, 0));
    st[3] = mk(1'b0, 1'b0, 16'h0000, es(1'b1, 0, 1'b0, 1'b0, 0));
    st[4] = mk(1'b0, 1'b0, 16'h0000, es(1'b0, 0, 1'b0, 1'b0, 0));
    for (int i = 0; i < 5; i++) begin
      in_vld = st[i].v; clr = st[i].c; in_data = st[i].d;
      tick();
      n_vec++;
      if (obs_s !== st[i].e) begin
        n_err++;
        $display("FAIL back_to_back step %0d: got %h expected %h", i, obs_s, st[i].e);
      end
    end
  endtask

  task automatic test_unsigned();
    step_t st[8];
    do_clr();
    st[0] = mk(1'b1, 1'b0, 16'h03FE, eu(1'b0, 0, 1'b0, 1'b0, 0));
    st[1] = mk(1'b1, 1'b0, 16'h0001, eu(1'b1, 1022, 1'b0, 1'b0, 0));
    st[2] = mk(1'b1, 1'b0, 16'h0001, eu(1'b1, 1023, 1'b0, 1'b0, 0));
    st[3] = mk(1'b1, 1'b0, 16'h0400, eu(1'b1, 1023, 1'b1, 1'b0, 1));
    st[4] = mk(1'b1, 1'b0, 16'h0400, eu(1'b1, 1023, 1'b1, 1'b0, 2));
    st[5] = mk(1'b1, 1'b0, 16'h0400, eu(1'b1, 1023, 1'b1, 1'b0, 3));
    st[6] = mk(1'b0, 1'b0, 16'h0000, eu(1'b1, 1023, 1'b1, 1'b0, 3));
    st[7] = mk(1'b0, 1'b0, 16'h0000, eu(1'b0, 1023, 1'b0, 1'b0, 3));
    for (int i = 0; i < 8; i++) begin
      in_vld = st[i].v; clr = st[i].c; in_data = st[i].d;
      tick();
      n_vec++;
      if (obs_u !== st[i].e) begin
        n_err++;
        $display("FAIL unsigned step %0d: got %h expected %h", i, obs_u, st[i].e);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_vld = 1'b0; in_data = 16'h0000;
    test_reset();
    test_signed_top();
    test_input_clip();
    test_signed_bottom();
    test_clr_collision();
    test_back_to_back();
    test_unsigned();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
